// File: rtl/whack_pkg.sv
// Shared definitions for the whack-a-mole input front end and game core.
// lowest_set picks the highest-priority (lowest index) pending button.
package whack_pkg;

    localparam int NUM_BTN   = 8;
    localparam int BTN_IDX_W = 3;

    typedef struct packed {
        logic                 found;
        logic [BTN_IDX_W-1:0] idx;
    } lowest_t;

    function automatic lowest_t lowest_set(input logic [NUM_BTN-1:0] vec);
        lowest_t res;
        res = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (vec[i]) begin
                res.found = 1'b1;
                res.idx   = BTN_IDX_W'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: two-flop synchroniser, tick-based debounce and rising-edge pulse.
// The counter only moves on ticks, so a glitch shorter than a tick interval cannot be accepted.
module btn_debounce #(
    parameter int DB_TICKS = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_ena,
    input  logic i_tick,
    input  logic i_btn,
    output logic o_rise
);

    logic [1:0] r_sync;
    logic       r_stable;
    logic       r_stableDly;
    logic [2:0] r_count;
    logic       w_synced;

    assign w_synced = r_sync[1];

    // Any sample that agrees with the stable level restarts the persistence count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync      <= '0;
            r_stable    <= 1'b0;
            r_stableDly <= 1'b0;
            r_count     <= '0;
        end else begin
            r_sync      <= {r_sync[0], i_btn};
            r_stableDly <= r_stable;
            if (i_ena) begin
                if (w_synced == r_stable) begin
                    r_count <= '0;
                end else if (i_tick) begin
                    if (r_count == 3'(DB_TICKS - 1)) begin
                        r_stable <= w_synced;
                        r_count  <= '0;
                    end else begin
                        r_count <= r_count + 3'd1;
                    end
                end
            end
        end
    end

    assign o_rise = r_stable & ~r_stableDly;

endmodule

// File: rtl/btn_event_encoder.sv
// Turns eight raw buttons into a stream of "button N pressed" events over valid/ready.
// One pending bit per button; a press that finds its bit already set is counted as dropped.
module btn_event_encoder
    import whack_pkg::*;
#(
    parameter int TICK_DIV = 1000,
    parameter int DB_TICKS = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [NUM_BTN-1:0]   btn,
    input  logic                 press_ready,
    output logic                 press_valid,
    output logic [BTN_IDX_W-1:0] press_idx,
    output logic [7:0]           drop_cnt
);

    localparam int PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [PRESC_W-1:0]   r_presc;
    logic                 w_tick;
    logic [NUM_BTN-1:0]   w_rise;
    logic [NUM_BTN-1:0]   r_pend;
    logic                 r_valid;
    logic [BTN_IDX_W-1:0] r_idx;
    logic [7:0]           r_drop;
    logic                 w_xfer;
    logic [NUM_BTN-1:0]   w_xferMask;
    logic [NUM_BTN-1:0]   w_cand;
    logic [NUM_BTN-1:0]   w_dropVec;
    lowest_t              w_next;

    assign w_tick = ena && (r_presc == PRESC_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (ena) begin
            r_presc <= w_tick ? '0 : r_presc + PRESC_W'(1);
        end
    end

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_debounce #(
            .DB_TICKS(DB_TICKS)
        ) u_debounce (
            .clk   (clk),
            .rst_n (rst_n),
            .i_ena (ena),
            .i_tick(w_tick),
            .i_btn (btn[g]),
            .o_rise(w_rise[g])
        );
    end

    assign w_xfer = r_valid && press_ready;

    always_comb begin
        w_xferMask = '0;
        if (w_xfer) begin
            w_xferMask[r_idx] = 1'b1;
        end
    end

    // A same-cycle re-press of the button being transferred keeps it eligible.
    assign w_cand    = r_pend & ~(w_xferMask & ~w_rise);
    assign w_dropVec = w_rise & r_pend & ~w_xferMask;
    assign w_next    = lowest_set(w_cand);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend  <= '0;
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_drop  <= '0;
        end else begin
            r_pend <= (r_pend & ~w_xferMask) | w_rise;
            if (!r_valid || w_xfer) begin
                r_valid <= w_next.found;
                if (w_next.found) begin
                    r_idx <= w_next.idx;
                end
            end
            if ((|w_dropVec) && (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 8'd1;
            end
        end
    end

    assign press_valid = r_valid;
    assign press_idx   = r_idx;
    assign drop_cnt    = r_drop;

endmodule

// File: tb/tb_btn_event_encoder.sv
// Scoreboard bench for btn_event_encoder: a reference model predicts transfers and outputs,
// a negedge monitor compares; directed scenarios add fixed expectations.
module tb_btn_event_encoder;

    localparam int TICK_DIV = 4;
    localparam int DB_TICKS = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] btn;
    logic       press_ready;
    logic       press_valid;
    logic [2:0] press_idx;
    logic [7:0] drop_cnt;

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    // Reference model state, advanced at every rising edge.
    logic [7:0] mSync0 = '0;
    logic [7:0] mS     = '0;
    logic [7:0] mSt    = '0;
    logic [7:0] mStD   = '0;
    logic [7:0] mPend  = '0;
    int         mWait[8];
    int         mPresc = 0;
    logic       mValid = 1'b0;
    int         mIdx   = 0;
    int         mDrop  = 0;

    int expQ[$];
    int seenLog[$];
    int seenCyc[$];

    btn_event_encoder #(
        .TICK_DIV(TICK_DIV),
        .DB_TICKS(DB_TICKS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .btn        (btn),
        .press_ready(press_ready),
        .press_valid(press_valid),
        .press_idx  (press_idx),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // A new level must survive DB_TICKS ticks while disagreeing with the accepted level.
    always @(posedge clk) begin : refModel
        logic [7:0] rise;
        logic [7:0] cand;
        logic [7:0] dropV;
        logic       xfer;
        logic       tick;
        int         xi;
        if (!rst_n) begin
            mSync0 = '0; mS = '0; mSt = '0; mStD = '0; mPend = '0;
            for (int i = 0; i < 8; i++) mWait[i] = 0;
            mPresc = 0; mValid = 1'b0; mIdx = 0; mDrop = 0;
        end else begin
            tick = ena && (mPresc == TICK_DIV - 1);
            rise = mSt & ~mStD;
            xfer = mValid && press_ready;
            xi   = mIdx;
            cand = mPend;
            if (xfer && !rise[xi]) cand[xi] = 1'b0;
            dropV = rise & mPend;
            if (xfer) dropV[xi] = 1'b0;
            if (dropV != 0 && mDrop < 255) mDrop++;
            if (xfer) begin
                expQ.push_back(xi);
                mPend[xi] = 1'b0;
            end
            mPend = mPend | rise;
            if (!mValid || xfer) begin
                mValid = 1'b0;
                for (int i = 7; i >= 0; i--) begin
                    if (cand[i]) begin
                        mValid = 1'b1;
                        mIdx   = i;
                    end
                end
            end
            mStD = mSt;
            if (ena) begin
                for (int i = 0; i < 8; i++) begin
                    if (mS[i] == mSt[i]) begin
                        mWait[i] = 0;
                    end else if (tick) begin
                        mWait[i]++;
                        if (mWait[i] == DB_TICKS) begin
                            mSt[i]   = mS[i];
                            mWait[i] = 0;
                        end
                    end
                end
                mPresc = (mPresc + 1) % TICK_DIV;
            end
            mS     = mSync0;
            mSync0 = btn;
        end
    end

    // A handshake seen at one negedge commits at the next rising edge; it is scored a cycle later.
    bit havePrev = 1'b0;
    int prevIdx  = 0;
    always @(negedge clk) begin
        if (havePrev) begin
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL xfer_unexpected: got idx %0d expected no transfer", prevIdx);
            end else begin
                checkOutput("xfer_idx", prevIdx, expQ.pop_front());
            end
            seenLog.push_back(prevIdx);
            seenCyc.push_back(cycle);
        end
        checkOutput("valid", press_valid, mValid);
        if (mValid) checkOutput("idx", press_idx, mIdx);
        checkOutput("drop_cnt", drop_cnt, mDrop);
        havePrev = rst_n && press_valid && press_ready;
        prevIdx  = press_idx;
    end

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic rdy, input int n);
        btn         = b;
        press_ready = rdy;
        waitCycles(n);
    endtask

    task automatic resetDut();
        rst_n       = 1'b0;
        btn         = '0;
        press_ready = 1'b0;
        ena         = 1'b1;
        waitCycles(2);
        rst_n = 1'b1;
        waitCycles(1);
        seenLog.delete();
        seenCyc.delete();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected test end");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit found;
        rst_n = 1'b0; ena = 1'b1; btn = '0; press_ready = 1'b0;
        for (int i = 0; i < 8; i++) mWait[i] = 0;
        waitCycles(3);
        checkOutput("rst_valid", press_valid, 0);
        checkOutput("rst_idx", press_idx, 0);
        checkOutput("rst_drop", drop_cnt, 0);
        rst_n = 1'b1;
        waitCycles(1);
        seenLog.delete();
        seenCyc.delete();

        // Single press of button 3, then release.
        applyStimulus(8'h08, 1'b1, 40);
        applyStimulus(8'h00, 1'b1, 40);
        checkOutput("s1_count", seenLog.size(), 1);
        if (seenLog.size() >= 1) checkOutput("s1_idx", seenLog[0], 3);

        // Bounce on button 5.
        resetDut();
        for (int k = 0; k < 15; k++) applyStimulus((k % 2 == 0) ? 8'h20 : 8'h00, 1'b1, 2);
        applyStimulus(8'h00, 1'b1, 40);
        checkOutput("s2_count", seenLog.size(), 0);
        checkOutput("s2_drop", drop_cnt, 0);

        // Simultaneous presses delivered lowest index first on consecutive cycles.
        resetDut();
        applyStimulus(8'b1000_0101, 1'b0, 1);
        for (int w = 0; w < 60 && !press_valid; w++) waitCycles(1);
        checkOutput("s3_valid_rise", press_valid, 1);
        applyStimulus(8'b1000_0101, 1'b1, 30);
        applyStimulus(8'h00, 1'b1, 40);
        checkOutput("s3_count", seenLog.size(), 3);
        if (seenLog.size() == 3) begin
            checkOutput("s3_first", seenLog[0], 0);
            checkOutput("s3_second", seenLog[1], 2);
            checkOutput("s3_third", seenLog[2], 7);
            checkOutput("s3_gap1", seenCyc[1] - seenCyc[0], 1);
            checkOutput("s3_gap2", seenCyc[2] - seenCyc[1], 1);
        end

        // Backpressure with a dropped re-press.
        resetDut();
        applyStimulus(8'h02, 1'b0, 40);
        checkOutput("s4_valid", press_valid, 1);
        checkOutput("s4_idx_a", press_idx, 1);
        applyStimulus(8'h00, 1'b0, 40);
        checkOutput("s4_idx_b", press_idx, 1);
        applyStimulus(8'h02, 1'b0, 40);
        checkOutput("s4_idx_c", press_idx, 1);
        checkOutput("s4_drop", drop_cnt, 1);
        applyStimulus(8'h02, 1'b1, 1);
        checkOutput("s4_valid_after", press_valid, 0);
        applyStimulus(8'h00, 1'b1, 40);
        checkOutput("s4_count", seenLog.size(), 1);

        // Re-press of button 4 landing on its own transfer cycle.
        resetDut();
        applyStimulus(8'h10, 1'b0, 40);
        applyStimulus(8'h00, 1'b0, 40);
        btn   = 8'h10;
        found = 1'b0;
        for (int w = 0; w < 60 && !found; w++) begin
            waitCycles(1);
            if (mSt[4] && !mStD[4]) found = 1'b1;
        end
        checkOutput("s5_rise_seen", found, 1);
        applyStimulus(8'h10, 1'b1, 1);
        press_ready = 1'b0;
        checkOutput("s5_represent", press_valid, 1);
        checkOutput("s5_idx", press_idx, 4);
        checkOutput("s5_drop", drop_cnt, 0);
        applyStimulus(8'h10, 1'b1, 5);
        applyStimulus(8'h00, 1'b1, 40);
        checkOutput("s5_count", seenLog.size(), 2);

        // Reset mid-handshake discards pending events and the drop count.
        resetDut();
        applyStimulus(8'h03, 1'b0, 20);
        applyStimulus(8'h00, 1'b0, 16);
        applyStimulus(8'h03, 1'b0, 20);
        checkOutput("s6_drop_before", drop_cnt, 1);
        checkOutput("s6_valid_before", press_valid, 1);
        rst_n = 1'b0;
        btn   = 8'h00;
        waitCycles(1);
        checkOutput("s6_valid_rst", press_valid, 0);
        checkOutput("s6_drop_rst", drop_cnt, 0);
        rst_n = 1'b1;
        seenLog.delete();
        seenCyc.delete();
        applyStimulus(8'h00, 1'b1, 40);
        checkOutput("s6_stale", seenLog.size(), 0);

        // Frozen debounce while ena is low.
        ena = 1'b0;
        applyStimulus(8'h40, 1'b1, 40);
        applyStimulus(8'h00, 1'b1, 40);
        ena = 1'b1;
        waitCycles(20);
        checkOutput("s6_ena_count", seenLog.size(), 0);

        // Repeated all-button drops: one count per cycle, saturating at 255.
        resetDut();
        for (int k = 0; k < 260; k++) begin
            applyStimulus(8'hFF, 1'b0, 14);
            applyStimulus(8'h00, 1'b0, 14);
            if (k == 1) checkOutput("sat_multi", drop_cnt, 1);
        end
        checkOutput("sat_drop", drop_cnt, 255);

        // Randomised traffic against the reference model.
        resetDut();
        for (int c = 0; c < 3000; c++) begin
            logic [7:0] b;
            b = btn;
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 23) == 0) b[i] = ~b[i];
            end
            ena = ($urandom_range(0, 19) != 0);
            rst_n = (c != 1500);
            applyStimulus(b, ($urandom_range(0, 9) < 7), 1);
        end
        rst_n = 1'b1;
        ena   = 1'b1;
        applyStimulus(8'h00, 1'b1, 60);
        checkOutput("leftover_expected", expQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/btn_event_encoder.md
# btn_event_encoder

Input-side front end for `tt_um_whack_a_mole`. It takes the eight raw player buttons, synchronises and debounces each one, and turns every debounced press into a single event. Events are queued per button and presented one at a time to the game FSM as a 3-bit button index over a valid/ready handshake. The game core then consumes discrete "button N pressed" events instead of sampling raw `btn` levels.

## Interface
- `TICK_DIV`, default 1000: clk cycles per debounce tick (1 ms at 1 MHz). Minimum 2.
- `DB_TICKS`, default 5: consecutive ticks a new level must persist before it is accepted. Range 1–7.
- `clk` input, 1 bit: single clock, 1 MHz nominal.
- `rst_n` input, 1 bit: synchronous, active-low reset.
- `ena` input, 1 bit: low freezes the prescaler and debounce counters. Sync flops, pending bits and the handshake keep operating.
- `btn` input, 8 bits: raw asynchronous buttons, active-high.
- `press_ready` input, 1 bit: the game FSM accepts the presented event.
- `press_valid` output, 1 bit: an event is presented.
- `press_idx` output, 3 bits: index of the pressed button. Meaningful only while `press_valid` is high.
- `drop_cnt` output, 8 bits: saturating count of presses lost because that button already had an event pending.

## Operation
- **Sync:** each `btn[i]` passes through 2 flops to give `s[i]`.
- **Prescaler:** counts 0..TICK_DIV-1 while `ena` is high. `tick` is high for one cycle when the count equals TICK_DIV-1, and the count wraps to 0 on that cycle.
- **Debounce (per bit):**
  - Holds stable level `st[i]` and counter `c[i]` (3 bits).
  - If `s[i]==st[i]`, then `c[i]<=0`.
  - Otherwise, on `tick`: if `c[i]==DB_TICKS-1`, then `st[i]<=s[i]` and `c[i]<=0`; else `c[i]++`.
  - Counters do not advance without a `tick`.
- **Event detection:** when `st[i]` goes 0→1, `rise[i]` is high for one cycle. Releases (1→0) generate nothing.
- **Pending set:** `pend[i]` is set by `rise[i]`.
- **Pending clear:** `pend[i]` is cleared when an event for `i` transfers (`press_valid && press_ready && press_idx==i`).
  - If `rise[i]` and that transfer happen in the same cycle, the set wins: `pend[i]` stays 1 and nothing is dropped.
- **Drop:** `rise[i]` while `pend[i]` is already 1, and no same-cycle transfer for `i`, increments `drop_cnt`. It saturates at 255 and counts at most +1 per cycle even if several buttons drop together.
- **Presenter:**
  - Loads when `press_valid==0`, or on a transfer cycle.
  - Loads the lowest-index set bit of `pend`, excluding the index being transferred that cycle unless the set-wins rule has re-set it.
  - If nothing qualifies, `press_valid<=0`.
  - While `press_valid && !press_ready`, `press_idx` and `press_valid` hold.
- **Reset:** all flops cleared, including mid-debounce and mid-handshake state. Events pending at reset are discarded.

## Timing
- **Reset values:** `press_valid`=0, `press_idx`=0, `drop_cnt`=0. Internally, `st`=0, `pend`=0, and the prescaler and `c` are 0.
- **Sync delay:** a `btn` edge reaches `s` 2 cycles later.
- **Debounce acceptance:** `st` changes on the DB_TICKS-th `tick` after `s` changes, provided `s` holds steady throughout. That is (DB_TICKS-1)·TICK_DIV to DB_TICKS·TICK_DIV cycles, depending on prescaler phase.
- **Event latency:** `st` rise → `pend` set is +1 cycle; `pend` set → `press_valid` high is +1 cycle when the presenter is idle.
- **Back-to-back transfers:** with `press_ready` tied high, a new pending index can be presented every cycle.
- **Bounce:** a glitch shorter than one full tick interval never changes `st`.

## Structure
- **Package `whack_pkg`:** `NUM_BTN=8`, `BTN_IDX_W=3`, and a `lowest_set` function (8 bits → 3 bits plus found flag). The package is shared with the game core.
- **Sub-module `btn_debounce`:** one per button, instantiated 8 times. It contains the sync, `st`, `c` and rise detect, and takes `tick` as an input.
- **Top level:** prescaler, pending vector, presenter and drop counter.

## Test plan
All scenarios use `TICK_DIV=4`, `DB_TICKS=2`.
1. **Single press:** `btn[3]`=1 held for 40 cycles, `press_ready`=1 → exactly one cycle with `press_valid`=1, `press_idx`=3. Release produces no event.
2. **Bounce rejection:** `btn[5]` toggled every 2 cycles for 30 cycles, then held low → no event, `drop_cnt`=0.
3. **Simultaneous presses:** `btn`=8'b1000_0101 asserted together, `press_ready`=0 until after `press_valid` rises, then 1 → indices 0, 2, 7 delivered in that order on consecutive cycles.
4. **Backpressure and drop:** `press_ready`=0; `btn[1]` pressed, released and pressed again, each level held 40 cycles → `press_idx`=1 holds steady and `drop_cnt`=1. Raise `press_ready` → one transfer, then `press_valid`=0.
5. **Set wins:** arrange `rise[4]` in the same cycle as the transfer of index 4 → `press_valid` re-presents 4 the next cycle, `drop_cnt` unchanged.
6. **Reset and enable:**
   - Assert `rst_n`=0 for 1 cycle while `press_valid`=1 with events pending → next cycle `press_valid`=0, `drop_cnt`=0, and no stale events afterwards.
   - With `ena`=0, a 40-cycle press produces no event.
